// File: rtl/tl45_mem_arbiter.sv
// tl45_mem_arbiter: shares a single Wishbone pipelined master port between the
// instruction-fetch requester and the load/store requester.
//
// Ports
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_flush                          pipeline flush (cancels fetch responses only)
//   i_f_req/i_f_addr                 fetch request and byte address
//   o_f_ack/o_f_err/o_f_data         fetch response pulse, error pulse, instruction word
//   i_d_req/i_d_we/i_d_addr/
//   i_d_wdata/i_d_sel                data request, direction, address, store data, lanes
//   o_d_ack/o_d_err/o_d_rdata        data response pulse, error pulse, load data
//   o_wb_*                           Wishbone master outputs (30-bit word address)
//   i_wb_ack/i_wb_err/i_wb_stall/
//   i_wb_data                        Wishbone slave responses
module tl45_mem_arbiter (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_f_req,
  input  logic [31:0] i_f_addr,
  output logic        o_f_ack,
  output logic        o_f_err,
  output logic [31:0] o_f_data,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_sel,
  output logic        o_d_ack,
  output logic        o_d_err,
  output logic [31:0] o_d_rdata,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StGap} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data port owns the cycle
  logic [29:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cancel_q, cancel_d;
  logic        f_ack_q, f_ack_d, f_err_q, f_err_d;
  logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0] f_data_q, f_data_d, d_rdata_q, d_rdata_d;
  logic        resp;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{i_f_addr[1:0], i_d_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    cancel_d  = cancel_q;
    f_ack_d   = 1'b0;
    f_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    f_data_d  = f_data_q;
    d_rdata_d = d_rdata_q;
    resp      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Data is older in the pipeline, so it always wins.
        if (i_d_req) begin
          owner_d = 1'b1;
          addr_d  = i_d_addr[31:2];
          we_d    = i_d_we;
          sel_d   = i_d_sel;
          wdata_d = i_d_wdata;
          state_d = StReq;
        end else if (i_f_req && !i_flush) begin
          owner_d = 1'b0;
          addr_d  = i_f_addr[31:2];
          we_d    = 1'b0;
          sel_d   = 4'hF;
          wdata_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (!i_wb_stall) begin
          state_d = StWait;
          // A response in the accepting cycle is taken immediately.
          resp    = i_wb_ack | i_wb_err;
        end
      end
      StWait: resp = i_wb_ack | i_wb_err;
      StGap: begin
        state_d  = StIdle;
        cancel_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StReq || state_q == StWait) && !owner_q && i_flush) begin
      cancel_d = 1'b1;
    end

    if (resp) begin
      state_d = StGap;
      if (owner_q) begin
        d_err_d   = i_wb_err;
        d_ack_d   = !i_wb_err;
        d_rdata_d = i_wb_err ? 32'h0 : i_wb_data;
      end else if (!(cancel_q || i_flush)) begin
        // Flush in the response cycle also discards the fetch result.
        f_err_d  = i_wb_err;
        f_ack_d  = !i_wb_err;
        f_data_d = i_wb_err ? 32'h0 : i_wb_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdata_q   <= '0;
      cancel_q  <= 1'b0;
      f_ack_q   <= 1'b0;
      f_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      f_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      cancel_q  <= cancel_d;
      f_ack_q   <= f_ack_d;
      f_err_q   <= f_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      f_data_q  <= f_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // cyc/stb decode straight from the state flop so reset drops them at once.
  assign o_wb_cyc  = (state_q == StReq) || (state_q == StWait);
  assign o_wb_stb  = (state_q == StReq);
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;
  assign o_wb_sel  = sel_q;
  assign o_f_ack   = f_ack_q;
  assign o_f_err   = f_err_q;
  assign o_f_data  = f_data_q;
  assign o_d_ack   = d_ack_q;
  assign o_d_err   = d_err_q;
  assign o_d_rdata = d_rdata_q;

endmodule
